// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher (AES-128/192/256 by parameter), one round per clock.
// A ciphertext is accepted in IDLE, nr rounds run in ROUND, and the plaintext
// is held in DONE until the sink takes it.

// One state column of an inverse round: the column arrives already
// inverse-shifted; InvSubBytes, AddRoundKey, then optional InvMixColumns.
module aes_inv_col (
  input  logic [31:0] col_in,
  input  logic [31:0] rkey,
  input  logic        mix,
  output logic [31:0] col_out
);
  logic [0:3][7:0] c_in, k_in, b, m;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] y);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse S-box: undo the affine map, then take the field inverse as x^254
  // (x^127 by square-and-multiply, then one final squaring); 0 maps to 0.
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] x, r;
    x = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    r = x;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), x);
    return gmul(r, r);
  endfunction

  assign c_in = col_in;
  assign k_in = rkey;

  // InvSubBytes then AddRoundKey, byte by byte
  always_comb begin
    b = '0;
    for (int k = 0; k < 4; k++) b[k] = inv_sbox(c_in[k]) ^ k_in[k];
  end

  // InvMixColumns: rows of {0e,0b,0d,09} rotated per output byte
  always_comb begin
    m = '0;
    for (int k = 0; k < 4; k++)
      m[k] = gmul(b[k], 8'h0e) ^ gmul(b[2'(k + 1)], 8'h0b) ^
             gmul(b[2'(k + 2)], 8'h0d) ^ gmul(b[2'(k + 3)], 8'h09);
  end

  assign col_out = mix ? m : b;
endmodule

module aes_decrypt_iter #(
  parameter int nk = 8,
  parameter int nb = 4,
  parameter int nr = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            in_cipher,
  input  logic [32*nb*(nr+1)-1:0] w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            out_msg,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t            fsm;
  logic [3:0]      r;
  // Column 0 sits in the top 32 bits, matching FIPS byte order of the 128-bit bus.
  logic [0:3][31:0] st, shifted, rkey, lkey, nxt;

  if (nr != nk + 6 || nb != 4) begin : g_bad_cfg
    $error("aes_decrypt_iter: nb must be 4 and nr must equal nk+6");
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    // InvShiftRows is pure wiring: row k of column c comes from column c-k
    for (genvar k = 0; k < 4; k++) begin : g_row
      assign shifted[c][31-8*k -: 8] = st[(c - k + 4) % 4][31-8*k -: 8];
    end
    assign lkey[c] = w[32*(nb*nr + c) +: 32];
    assign rkey[c] = w[32*(nb*int'(r) + c) +: 32];
    aes_inv_col u_col (
      .col_in (shifted[c]),
      .rkey   (rkey[c]),
      .mix    (r != 4'd0),
      .col_out(nxt[c])
    );
  end

  // Control FSM with registered handshake outputs and the round state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      st        <= '0;
      r         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_msg   <= '0;
    end else begin
      case (fsm)
        IDLE: if (in_valid && in_ready) begin
          st       <= in_cipher ^ lkey;
          r        <= 4'(nr - 1);
          fsm      <= ROUND;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        ROUND: begin
          st <= nxt;
          if (r == 4'd0) begin
            fsm       <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            out_msg   <= nxt;
          end else begin
            r <= r - 4'd1;
          end
        end
        DONE: if (out_ready) begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          fsm       <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS-197 known answers at all three key sizes,
// back-pressure, mid-operation reset, and a randomized round trip against an
// AES encryption model held in the bench.
module tb_aes_decrypt_iter;
  logic clk, rst_n;
  logic iv [3], ir [3], ov [3], ordy [3], bz [3];
  logic [127:0]  ict [3], omsg [3];
  logic [1919:0] wk [3];

  int n_cmp = 0, n_bad = 0;
  logic [7:0] sb [256];

  // instance g: nk = 4+2g; index 2 is the AES-256 block used for most tests
  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_decrypt_iter #(.nk(4 + 2*g), .nb(4), .nr(10 + 2*g)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]),
      .in_cipher(ict[g]), .w(wk[g][32*4*(11+2*g)-1:0]), .out_valid(ov[g]),
      .out_ready(ordy[g]), .out_msg(omsg[g]), .busy(bz[g]));
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0; t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] t;
    t = (x == 8'h00) ? 8'h00 : 8'h01;
    if (x != 8'h00) for (int i = 0; i < 254; i++) t = gm(t, x);
    return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0] wd [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1919:0] v;
    rc = 8'h01; v = '0;
    for (int i = 0; i < 4*(nk+7); i++) begin
      if (i < nk) wd[i] = key[255-32*i -: 32];
      else begin
        t = wd[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gm(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        wd[i] = wd[i-nk] ^ t;
      end
      v[32*i +: 32] = wd[i];
    end
    return v;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] wv, input int nr);
    logic [7:0] s [16], t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int i = 0; i < 16; i++) s[i] ^= wv[32*(i/4) + 31 - 8*(i%4) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++) t[4*c+k] = s[4*((c+k)%4)+k];
      s = t;
      if (rd != nr) begin
        for (int c = 0; c < 4; c++)
          for (int k = 0; k < 4; k++)
            t[4*c+k] = gm(8'h02, s[4*c+k]) ^ gm(8'h03, s[4*c+(k+1)%4]) ^
                       s[4*c+(k+2)%4] ^ s[4*c+(k+3)%4];
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] ^= wv[32*(4*rd + i/4) + 31 - 8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- sequences ----------------
  // Runs one block through instance k from an idle sample point, out_ready high.
  task automatic run_block(input int k, input logic [127:0] ct, input logic [127:0] pt,
                           input int lat, input string tag);
    int cyc;
    ict[k] = ct; iv[k] = 1'b1; ordy[k] = 1'b1;
    chk({tag, " in_ready_idle"}, 128'(ir[k]), 128'(1));
    @(posedge clk); #1;
    iv[k] = 1'b0;
    chk({tag, " busy_round"}, 128'(bz[k]), 128'(1));
    chk({tag, " in_ready_round"}, 128'(ir[k]), 128'(0));
    cyc = 0;
    while (!ov[k] && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk({tag, " latency"}, 128'(cyc), 128'(lat));
    chk({tag, " plaintext"}, omsg[k], pt);
    chk({tag, " no_overlap"}, 128'(ir[k]), 128'(0));
    @(posedge clk); #1;
    chk({tag, " valid_one_cycle"}, 128'(ov[k]), 128'(0));
    chk({tag, " in_ready_after"}, 128'(ir[k]), 128'(1));
  endtask

  typedef struct {
    int           idx;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
  } kat_t;

  initial begin
    kat_t kats [3];
    logic [127:0] pt0, pt2, ct2, pt, key_lo;
    logic [255:0] key;
    logic [127:0] exp_q [$];
    int cyc, spur, got;

    pt0 = 128'h00112233445566778899aabbccddeeff;
    kats[0] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, pt0, 10};
    kats[1] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'hdda97ca4864cdfe06eaf70a0ec0d7191, pt0, 12};
    kats[2] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089, pt0, 14};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; ict[k] = '0; wk[k] = '0;
    end
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));

    #12;
    chk("reset in_ready", 128'(ir[2]), 128'(1));
    chk("reset out_valid", 128'(ov[2]), 128'(0));
    chk("reset busy", 128'(bz[2]), 128'(0));
    chk("reset out_msg", omsg[2], 128'(0));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // known-answer table
    for (int i = 0; i < 3; i++) begin
      wk[kats[i].idx] = expand(kats[i].key, 4 + 2*kats[i].idx);
      run_block(kats[i].idx, kats[i].ct, kats[i].pt, kats[i].lat,
                $sformatf("kat%0d", 128 + 64*i));
    end

    // back-pressure with a second ciphertext held on the input the whole time
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    ct2 = encrypt(pt2, wk[2], 14);
    ict[2] = kats[2].ct; iv[2] = 1'b1; ordy[2] = 1'b0;
    @(posedge clk); #1;
    ict[2] = ct2;
    cyc = 0;
    while (!ov[2] && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("bp first plaintext", omsg[2], pt0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp hold valid", 128'(ov[2]), 128'(1));
      chk("bp hold msg", omsg[2], pt0);
      chk("bp hold in_ready", 128'(ir[2]), 128'(0));
    end
    ordy[2] = 1'b1;
    @(posedge clk); #1;
    chk("bp released valid", 128'(ov[2]), 128'(0));
    chk("bp not yet accepted", 128'(bz[2]), 128'(0));
    @(posedge clk); #1;
    iv[2] = 1'b0;
    chk("bp second accepted", 128'(bz[2]), 128'(1));
    cyc = 0;
    while (!ov[2] && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("bp second latency", 128'(cyc), 128'(14));
    chk("bp second plaintext", omsg[2], pt2);
    @(posedge clk); #1;

    // asynchronous reset in the middle of round 5
    ict[2] = kats[2].ct; iv[2] = 1'b1;
    @(posedge clk); #1;
    iv[2] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #3 rst_n = 1'b0;
    #1;
    chk("midreset in_ready", 128'(ir[2]), 128'(1));
    chk("midreset out_valid", 128'(ov[2]), 128'(0));
    chk("midreset busy", 128'(bz[2]), 128'(0));
    chk("midreset out_msg", omsg[2], 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    spur = 0;
    repeat (20) begin @(posedge clk); #1; if (ov[2]) spur++; end
    chk("midreset spurious valid", 128'(spur), 128'(0));
    run_block(2, kats[2].ct, pt0, 14, "after_reset");

    // randomized round trip with gaps on both handshakes
    for (int n = 0; n < 200; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      iv[2] = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      wk[2] = expand(key, 8);
      ict[2] = encrypt(pt, wk[2], 14);
      exp_q.push_back(pt);
      iv[2] = 1'b1;
      @(posedge clk); #1;
      iv[2] = 1'b0;
      got = 0; cyc = 0;
      while (!got && cyc < 100) begin
        ordy[2] = 1'($urandom_range(0, 1));
        if (ov[2] && ordy[2]) begin
          key_lo = exp_q.pop_front();
          chk($sformatf("roundtrip %0d", n), omsg[2], key_lo);
          chk("roundtrip no_overlap", 128'(ir[2]), 128'(0));
          got = 1;
        end
        @(posedge clk); #1; cyc++;
      end
      if (!got) chk($sformatf("roundtrip %0d timeout", n), 128'(0), 128'(1));
    end
    ordy[2] = 1'b1;
    spur = 0;
    repeat (20) begin @(posedge clk); #1; if (ov[2]) spur++; end
    chk("roundtrip no duplicate", 128'(spur), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
